// File: rtl/vip_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vip_pkg
// Description : Shared widths, segment record and FSM state for the plate
//               projection stages.
// Revision    : 1.0
// ============================================================================
package vip_pkg;

  localparam int COORD_W = 10;
  localparam int CNT_W   = 10;

  typedef struct packed {
    logic [COORD_W-1:0] left;
    logic [COORD_W-1:0] right;
  } seg_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_SCAN  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Add inc to a column count without wrapping past the all-ones value.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] base,
                                               input logic             inc);
    return (inc && (base != {CNT_W{1'b1}})) ? base + CNT_W'(1) : base;
  endfunction

endpackage
`default_nettype wire

// File: rtl/vip_col_hist_ram.sv
`default_nettype none
// ============================================================================
// Module      : vip_col_hist_ram
// Description : Simple dual-port column histogram, one write port and one
//               registered read port (read latency 1).
// Revision    : 1.0
// ============================================================================
module vip_col_hist_ram #(
  parameter int DEPTH = 640,
  parameter int DW    = 10,
  parameter int AW    = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] rdata_q;

  // Storage is deliberately unreset; the first line of each frame rewrites it.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule
`default_nettype wire

// File: rtl/vip_char_segment.sv
`default_nettype none
// ============================================================================
// Module      : vip_char_segment
// Description : Vertical-projection character segmentation: per-column pixel
//               histogram inside the plate band, scanned after frame end.
// Revision    : 1.0
// ============================================================================
module vip_char_segment
  import vip_pkg::*;
#(
  parameter int IMG_HDISP = 640,
  parameter int IMG_VDISP = 480,
  parameter int MAX_CHARS = 8,
  parameter int COL_TH    = 2,
  parameter int MIN_WIDTH = 3
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         per_frame_vsync,
  input  logic                         per_frame_href,
  input  logic                         per_frame_clken,
  input  logic                         per_img_bit,
  input  logic [COORD_W-1:0]           row_up,
  input  logic [COORD_W-1:0]           row_down,
  input  logic [COORD_W-1:0]           col_start,
  input  logic [COORD_W-1:0]           col_end,
  output logic                         post_frame_vsync,
  output logic                         post_frame_href,
  output logic                         post_frame_clken,
  output logic                         post_img_bit,
  output logic [3:0]                   char_num,
  output logic [COORD_W*MAX_CHARS-1:0] char_left,
  output logic [COORD_W*MAX_CHARS-1:0] char_right,
  output logic                         char_overflow,
  output logic                         seg_valid
);

  localparam int                 HW       = $clog2(IMG_HDISP);
  localparam logic [COORD_W-1:0] X_LAST   = COORD_W'(IMG_HDISP - 1);
  localparam logic [COORD_W-1:0] Y_LAST   = COORD_W'(IMG_VDISP - 1);
  localparam logic [COORD_W:0]   SCAN_END = (COORD_W + 1)'(IMG_HDISP);
  localparam logic [CNT_W-1:0]   OCC_TH   = CNT_W'(COL_TH);
  localparam logic [COORD_W:0]   SPAN_MIN = (COORD_W + 1)'(MIN_WIDTH - 1);
  localparam logic [3:0]         N_MAX    = 4'(MAX_CHARS);

  // Pass-through pipe and edge detection; pipe1_q[3] doubles as vsync history.
  logic [3:0] pipe1_q, pipe2_q;
  logic       w_vs_rise, w_vs_fall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe1_q <= '0;
      pipe2_q <= '0;
    end else begin
      pipe1_q <= {per_frame_vsync, per_frame_href, per_frame_clken, per_img_bit};
      pipe2_q <= pipe1_q;
    end
  end

  assign {post_frame_vsync, post_frame_href, post_frame_clken, post_img_bit} = pipe2_q;
  assign w_vs_rise =  per_frame_vsync & ~pipe1_q[3];
  assign w_vs_fall = ~per_frame_vsync &  pipe1_q[3];

  logic [COORD_W-1:0] row_up_q, row_down_q, col_start_q, col_end_q;
  logic [COORD_W-1:0] x_q, y_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_up_q    <= '0;
      row_down_q  <= '0;
      col_start_q <= '0;
      col_end_q   <= '0;
      x_q         <= '0;
      y_q         <= '0;
    end else if (w_vs_rise) begin
      row_up_q    <= row_up;
      row_down_q  <= row_down;
      col_start_q <= col_start;
      col_end_q   <= col_end;
      x_q         <= '0;
      y_q         <= '0;
    end else if (per_frame_clken) begin
      if (x_q == X_LAST) begin
        x_q <= '0;
        y_q <= (y_q == Y_LAST) ? '0 : y_q + COORD_W'(1);
      end else begin
        x_q <= x_q + COORD_W'(1);
      end
    end
  end

  // Accumulate pipeline: stage 0 reads column x, stage 1 writes count+inc.
  logic          w_inc;
  logic [HW-1:0] acc_x_q;
  logic          acc_first_q, acc_inc_q, acc_vld_q;

  assign w_inc = per_img_bit
               & (y_q >= row_up_q)    & (y_q <= row_down_q)
               & (x_q >= col_start_q) & (x_q <= col_end_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_x_q     <= '0;
      acc_first_q <= 1'b0;
      acc_inc_q   <= 1'b0;
      acc_vld_q   <= 1'b0;
    end else begin
      acc_x_q     <= x_q[HW-1:0];
      acc_first_q <= (y_q == '0);
      acc_inc_q   <= w_inc;
      acc_vld_q   <= per_frame_clken;
    end
  end

  state_e              state_q, state_d;
  logic [COORD_W:0]    scan_cnt_q;
  logic [CNT_W-1:0]    w_ram_rdata;
  logic [CNT_W-1:0]    w_ram_wdata;
  logic [HW-1:0]       w_ram_raddr;

  // Line 0 overwrites instead of accumulating, clearing last frame's counts.
  assign w_ram_wdata = sat_inc(acc_first_q ? '0 : w_ram_rdata, acc_inc_q);
  assign w_ram_raddr = (state_q == ST_SCAN) ? scan_cnt_q[HW-1:0] : x_q[HW-1:0];

  vip_col_hist_ram #(
    .DEPTH (IMG_HDISP),
    .DW    (CNT_W),
    .AW    (HW)
  ) u_hist (
    .clk     (clk),
    .rst_n   (rst_n),
    .we_i    (acc_vld_q),
    .waddr_i (acc_x_q),
    .wdata_i (w_ram_wdata),
    .raddr_i (w_ram_raddr),
    .rdata_o (w_ram_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (w_vs_rise) state_d = ST_ACCUM;
      ST_ACCUM: if (w_vs_fall) state_d = ST_SCAN;
      ST_SCAN: begin
        if (w_vs_rise)                    state_d = ST_ACCUM;
        else if (scan_cnt_q == SCAN_END)  state_d = ST_DONE;
      end
      ST_DONE:  state_d = w_vs_rise ? ST_ACCUM : ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  logic w_scan_start, w_scan_en, w_done;

  always_comb begin
    w_scan_start = 1'b0;
    w_scan_en    = 1'b0;
    w_done       = 1'b0;
    case (state_q)
      ST_ACCUM: w_scan_start = w_vs_fall;
      ST_SCAN:  w_scan_en    = 1'b1;
      ST_DONE:  w_done       = 1'b1;
      default:  ;
    endcase
  end

  // Scan: column (scan_cnt-1) is judged while column scan_cnt is being read.
  logic               in_seg_q, in_seg_d;
  logic [COORD_W-1:0] left_tmp_q, left_tmp_d;
  logic [3:0]         n_q;
  logic               ovf_q;
  logic               w_proc, w_occ, w_last, w_close, w_width_ok, w_room, w_store;
  logic [COORD_W-1:0] w_col, w_cl_left, w_cl_right;
  logic [COORD_W:0]   w_span;

  assign w_proc = w_scan_en & (scan_cnt_q != '0);
  assign w_col  = COORD_W'(scan_cnt_q - (COORD_W + 1)'(1));
  assign w_occ  = (w_ram_rdata >= OCC_TH);
  assign w_last = (w_col == X_LAST);

  always_comb begin
    in_seg_d   = in_seg_q;
    left_tmp_d = left_tmp_q;
    w_close    = 1'b0;
    w_cl_left  = left_tmp_q;
    w_cl_right = w_col;
    if (w_proc) begin
      if (w_occ) begin
        if (!in_seg_q) begin
          left_tmp_d = w_col;
          w_cl_left  = w_col;
          in_seg_d   = 1'b1;
        end
        if (w_last) begin
          w_close    = 1'b1;
          w_cl_right = X_LAST;
          in_seg_d   = 1'b0;
        end
      end else if (in_seg_q) begin
        w_close    = 1'b1;
        w_cl_right = w_col - COORD_W'(1);
        in_seg_d   = 1'b0;
      end
    end
  end

  assign w_span     = {1'b0, w_cl_right} - {1'b0, w_cl_left};
  assign w_width_ok = (w_span >= SPAN_MIN);
  assign w_room     = (n_q < N_MAX);
  assign w_store    = w_close & w_width_ok & w_room;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt_q <= '0;
      in_seg_q   <= 1'b0;
      left_tmp_q <= '0;
      n_q        <= '0;
      ovf_q      <= 1'b0;
    end else if (w_scan_start) begin
      scan_cnt_q <= '0;
      in_seg_q   <= 1'b0;
      n_q        <= '0;
      ovf_q      <= 1'b0;
    end else if (w_scan_en) begin
      scan_cnt_q <= scan_cnt_q + (COORD_W + 1)'(1);
      in_seg_q   <= in_seg_d;
      left_tmp_q <= left_tmp_d;
      if (w_close && w_width_ok) begin
        if (w_room) n_q   <= n_q + 4'd1;
        else        ovf_q <= 1'b1;
      end
    end
  end

  seg_t seg_q     [MAX_CHARS];
  seg_t out_seg_q [MAX_CHARS];

  generate
    for (genvar i = 0; i < MAX_CHARS; i++) begin : g_slot
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          seg_q[i] <= '0;
        end else if (w_store && (n_q == 4'(i))) begin
          seg_q[i] <= '{left: w_cl_left, right: w_cl_right};
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          out_seg_q[i] <= '0;
        end else if (w_done) begin
          out_seg_q[i] <= (4'(i) < n_q) ? seg_q[i] : '0;
        end
      end

      assign char_left [i*COORD_W +: COORD_W] = out_seg_q[i].left;
      assign char_right[i*COORD_W +: COORD_W] = out_seg_q[i].right;
    end
  endgenerate

  logic [3:0] char_num_q;
  logic       char_overflow_q, seg_valid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      char_num_q      <= '0;
      char_overflow_q <= 1'b0;
      seg_valid_q     <= 1'b0;
    end else begin
      seg_valid_q <= w_done;
      if (w_done) begin
        char_num_q      <= n_q;
        char_overflow_q <= ovf_q;
      end
    end
  end

  assign char_num      = char_num_q;
  assign char_overflow = char_overflow_q;
  assign seg_valid     = seg_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_vip_char_segment.sv
`default_nettype none
// ============================================================================
// Module      : tb_vip_char_segment
// Description : Directed vector bench for vip_char_segment on a 64x16 frame.
// Revision    : 1.0
// ============================================================================
module tb_vip_char_segment;

  localparam int HD = 64;
  localparam int VD = 16;
  localparam int NV = 11;
  localparam int LAT = HD + 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        vsync = 1'b0, href = 1'b0, clken = 1'b0, pbit = 1'b0;
  logic [9:0]  row_up = '0, row_down = '0, col_start = '0, col_end = '0;
  logic        post_vsync, post_href, post_clken, post_bit;
  logic [3:0]  char_num;
  logic [79:0] char_left, char_right;
  logic        char_overflow, seg_valid;

  vip_char_segment #(
    .IMG_HDISP (HD),
    .IMG_VDISP (VD),
    .MAX_CHARS (8),
    .COL_TH    (2),
    .MIN_WIDTH (3)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .per_frame_vsync  (vsync),
    .per_frame_href   (href),
    .per_frame_clken  (clken),
    .per_img_bit      (pbit),
    .row_up           (row_up),
    .row_down         (row_down),
    .col_start        (col_start),
    .col_end          (col_end),
    .post_frame_vsync (post_vsync),
    .post_frame_href  (post_href),
    .post_frame_clken (post_clken),
    .post_img_bit     (post_bit),
    .char_num         (char_num),
    .char_left        (char_left),
    .char_right       (char_right),
    .char_overflow    (char_overflow),
    .seg_valid        (seg_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [9:0]  up, dn, cs, ce;
    logic [63:0] cols;
    logic [15:0] rows;
    logic [3:0]  num;
    logic        ovf;
    logic [79:0] left, right;
  } vec_t;

  vec_t vec [NV];
  int   tests = 0;
  int   fails = 0;
  int   sv_cnt = 0;
  int   pt_err = 0;

  // Two-clock delay reference for the pass-through outputs.
  logic [3:0] pt1, pt2;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pt1 <= '0;
      pt2 <= '0;
    end else begin
      pt1 <= {vsync, href, clken, pbit};
      pt2 <= pt1;
    end
  end

  always @(negedge clk) begin
    if (seg_valid) sv_cnt++;
    if ({post_vsync, post_href, post_clken, post_bit} !== pt2) begin
      if (pt_err < 3)
        $display("passthrough differs at %0t: got %b want %b", $time,
                 {post_vsync, post_href, post_clken, post_bit}, pt2);
      pt_err++;
    end
  end

  function automatic logic [63:0] cm(input int lo, input int hi);
    logic [63:0] m = '0;
    for (int i = lo; i <= hi; i++) m[i] = 1'b1;
    return m;
  endfunction

  function automatic logic [15:0] rm(input int lo, input int hi);
    logic [15:0] m = '0;
    for (int i = lo; i <= hi; i++) m[i] = 1'b1;
    return m;
  endfunction

  function automatic logic [79:0] pk(input int a0, a1, a2, a3, a4, a5, a6, a7);
    return {10'(a7), 10'(a6), 10'(a5), 10'(a4), 10'(a3), 10'(a2), 10'(a1), 10'(a0)};
  endfunction

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic frame_start(input logic [9:0] up, dn, cs, ce);
    @(posedge clk); #1;
    row_up = up; row_down = dn; col_start = cs; col_end = ce;
    vsync = 1'b1;
    // Bounds change right after the rise; the DUT must keep the latched ones.
    @(posedge clk); #1;
    row_up = 10'd0; row_down = 10'd15; col_start = 10'd0; col_end = 10'd63;
    repeat (2) @(posedge clk);
  endtask

  task automatic frame_body(input logic [63:0] cols, input logic [15:0] rows, input int nlines);
    for (int y = 0; y < nlines; y++) begin
      for (int x = 0; x < HD; x++) begin
        @(posedge clk); #1;
        href = 1'b1; clken = 1'b1; pbit = cols[x] & rows[y];
      end
      @(posedge clk); #1;
      href = 1'b0; clken = 1'b0; pbit = 1'b0;
      repeat (3) @(posedge clk);
    end
  endtask

  task automatic frame_stop();
    repeat (2) @(posedge clk);
    #1 vsync = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    bit found = 0;
    lat = 0;
    for (int i = 0; i < 4 * LAT && !found; i++) begin
      @(posedge clk); #1;
      lat++;
      if (seg_valid) found = 1;
    end
    if (!found) lat = -1;
  endtask

  task automatic check_result(input vec_t v, input string tag, input int sv_before);
    int lat;
    wait_valid(lat);
    chk({tag, "_latency"}, 80'(lat), 80'(LAT));
    chk({tag, "_num"},   80'(char_num), 80'(v.num));
    chk({tag, "_left"},  char_left,  v.left);
    chk({tag, "_right"}, char_right, v.right);
    chk({tag, "_ovf"},   80'(char_overflow), 80'(v.ovf));
    @(posedge clk); #1;
    chk({tag, "_pulse_width"}, 80'(seg_valid), 80'(0));
    chk({tag, "_pulse_count"}, 80'(sv_cnt - sv_before), 80'(1));
  endtask

  task automatic run_vec(input int idx);
    int sv0 = sv_cnt;
    frame_start(vec[idx].up, vec[idx].dn, vec[idx].cs, vec[idx].ce);
    frame_body(vec[idx].cols, vec[idx].rows, VD);
    frame_stop();
    check_result(vec[idx], $sformatf("v%0d", idx), sv0);
  endtask

  initial begin
    logic [63:0] ov_cols = '0;
    logic [79:0] ov_l = '0, ov_r = '0;
    int sv0;

    for (int k = 0; k < 10; k++) ov_cols |= cm(5 * k, 5 * k + 2);
    for (int k = 0; k < 8; k++) begin
      ov_l[10*k +: 10] = 10'(5 * k);
      ov_r[10*k +: 10] = 10'(5 * k + 2);
    end

    vec[0]  = '{10'd4,  10'd11, 10'd0,  10'd63, cm(5,9) | cm(20,27), rm(4,11), 4'd2, 1'b0,
                pk(5,20,0,0,0,0,0,0),  pk(9,27,0,0,0,0,0,0)};
    vec[1]  = '{10'd4,  10'd11, 10'd0,  10'd63, cm(10,11) | cm(30,35), rm(4,11), 4'd1, 1'b0,
                pk(30,0,0,0,0,0,0,0),  pk(35,0,0,0,0,0,0,0)};
    vec[2]  = '{10'd4,  10'd11, 10'd0,  10'd63, cm(5,9), rm(0,3), 4'd0, 1'b0, '0, '0};
    vec[3]  = '{10'd4,  10'd11, 10'd0,  10'd55, cm(50,60), rm(4,11), 4'd1, 1'b0,
                pk(50,0,0,0,0,0,0,0),  pk(55,0,0,0,0,0,0,0)};
    vec[4]  = '{10'd4,  10'd11, 10'd0,  10'd63, cm(58,63), rm(4,11), 4'd1, 1'b0,
                pk(58,0,0,0,0,0,0,0),  pk(63,0,0,0,0,0,0,0)};
    vec[5]  = '{10'd4,  10'd11, 10'd0,  10'd63, ov_cols, rm(4,11), 4'd8, 1'b1, ov_l, ov_r};
    vec[6]  = '{10'd11, 10'd4,  10'd0,  10'd63, cm(5,9), rm(0,15), 4'd0, 1'b0, '0, '0};
    vec[7]  = '{10'd4,  10'd11, 10'd40, 10'd10, cm(5,9), rm(0,15), 4'd0, 1'b0, '0, '0};
    vec[8]  = '{10'd4,  10'd11, 10'd0,  10'd63, cm(12,16), rm(4,4), 4'd0, 1'b0, '0, '0};
    vec[9]  = '{10'd4,  10'd11, 10'd0,  10'd63, cm(12,16), rm(4,5), 4'd1, 1'b0,
                pk(12,0,0,0,0,0,0,0),  pk(16,0,0,0,0,0,0,0)};
    vec[10] = '{10'd4,  10'd11, 10'd0,  10'd63, cm(0,3) | cm(63,63), rm(4,11), 4'd1, 1'b0,
                pk(0,0,0,0,0,0,0,0),   pk(3,0,0,0,0,0,0,0)};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_num",   80'(char_num), 80'(0));
    chk("rst_left",  char_left, 80'(0));
    chk("rst_right", char_right, 80'(0));
    chk("rst_ovf",   80'(char_overflow), 80'(0));
    chk("rst_valid", 80'(seg_valid), 80'(0));
    chk("rst_post",  80'({post_vsync, post_href, post_clken, post_bit}), 80'(0));
    @(posedge clk); #1 rst_n = 1'b1;

    for (int i = 0; i < NV; i++) run_vec(i);

    // A new vsync during the scan aborts it: no pulse, outputs keep vec[NV-1].
    sv0 = sv_cnt;
    frame_start(10'd4, 10'd11, 10'd0, 10'd63);
    frame_body(cm(40,45), rm(4,11), VD);
    frame_stop();
    repeat (20) @(posedge clk);
    frame_start(vec[0].up, vec[0].dn, vec[0].cs, vec[0].ce);
    frame_body(vec[0].cols, vec[0].rows, VD);
    chk("abort_no_pulse", 80'(sv_cnt - sv0), 80'(0));
    chk("abort_num",   80'(char_num), 80'(vec[NV-1].num));
    chk("abort_left",  char_left,  vec[NV-1].left);
    chk("abort_right", char_right, vec[NV-1].right);
    frame_stop();
    check_result(vec[0], "after_abort", sv0);

    // Reset in the middle of accumulation
    frame_start(vec[1].up, vec[1].dn, vec[1].cs, vec[1].ce);
    frame_body(vec[1].cols, vec[1].rows, 6);
    @(posedge clk); #1;
    rst_n = 1'b0; vsync = 1'b0; href = 1'b0; clken = 1'b0; pbit = 1'b0;
    #1;
    chk("mid_rst_num",   80'(char_num), 80'(0));
    chk("mid_rst_left",  char_left, 80'(0));
    chk("mid_rst_right", char_right, 80'(0));
    chk("mid_rst_valid", 80'(seg_valid), 80'(0));
    chk("mid_rst_post",  80'({post_vsync, post_href, post_clken, post_bit}), 80'(0));
    chk("mid_rst_state", 80'(dut.state_q), 80'(0));
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    run_vec(1);

    chk("passthrough_errors", 80'(pt_err), 80'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
